// File: rtl/alsu_seg_display.sv
// alsu_seg_display: ALSU result to decimal on a 4-digit multiplexed 7-segment display, with an error banner
module alsu_seg_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  out_in,
  input  logic [15:0] leds_in,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        conv_busy
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
  localparam logic [3:0] CH_E = 4'd10;
  localparam logic [3:0] CH_R = 4'd11;
  localparam logic [3:0] CH_BL = 4'd15;
  typedef enum logic {IDLE, CONV} state_t;
  state_t state, nxt;
  logic [5:0] shadow;
  logic [13:0] sr, sr_nxt;
  logic [3:0] adj_t, adj_o, ones, tens, cur;
  logic [2:0] step;
  logic [CW-1:0] scan;
  logic [1:0] idx;
  logic start, done, err;
  function automatic logic [6:0] decode(input logic [3:0] c);
    case (c)
      4'd0: decode = 7'b1000000;
      4'd1: decode = 7'b1111001;
      4'd2: decode = 7'b0100100;
      4'd3: decode = 7'b0110000;
      4'd4: decode = 7'b0011001;
      4'd5: decode = 7'b0010010;
      4'd6: decode = 7'b0000010;
      4'd7: decode = 7'b1111000;
      4'd8: decode = 7'b0000000;
      4'd9: decode = 7'b0010000;
      CH_E: decode = 7'b0000110;
      CH_R: decode = 7'b0101111;
      default: decode = 7'b1111111;
    endcase
  endfunction
  assign adj_t = sr[13:10] >= 4'd5 ? sr[13:10] + 4'd3 : sr[13:10];
  assign adj_o = sr[9:6] >= 4'd5 ? sr[9:6] + 4'd3 : sr[9:6];
  assign sr_nxt = {adj_t, adj_o, sr[5:0]} << 1;
  assign start = state == IDLE && out_in != shadow;
  assign done = state == CONV && step == 3'd5;
  assign err = |leds_in;
  assign dp = 1'b1;
  // conversion FSM state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  // next state: a new input value starts a conversion, the sixth shift ends it
  always_comb
    nxt = start ? CONV : done ? IDLE : state;
  // busy flag follows the CONV state
  always_comb
    conv_busy = state == CONV;
  // double-dabble datapath: load on start, add-3/shift each CONV cycle, publish digits on the last step
  always_ff @(posedge clk)
    if (rst) begin
      shadow <= '0;
      sr <= '0;
      step <= '0;
      ones <= '0;
      tens <= '0;
    end else if (start) begin
      shadow <= out_in;
      sr <= {8'd0, out_in};
      step <= '0;
    end else if (state == CONV) begin
      sr <= sr_nxt;
      step <= step + 3'd1;
      if (done) {tens, ones} <= sr_nxt[13:6];
    end
  // refresh scan: each digit stays selected for REFRESH_DIV cycles
  always_ff @(posedge clk)
    if (rst) begin
      scan <= '0;
      idx <= '0;
    end else if (scan == LAST) begin
      scan <= '0;
      idx <= idx + 2'd1;
    end else scan <= scan + 1'b1;
  // character for the selected digit; the error banner overrides the number immediately
  always_comb
    cur = err ? (idx == 2'd3 ? CH_E : idx == 2'd0 ? CH_BL : CH_R)
              : idx == 2'd0 ? ones : (idx == 2'd1 && tens != 4'd0) ? tens : CH_BL;
  // registered anode/segment drive
  always_ff @(posedge clk)
    if (rst) begin
      anode <= 4'b1111;
      seg <= 7'b1111111;
    end else begin
      anode <= ~(4'b0001 << idx);
      seg <= decode(cur);
    end
endmodule

// File: tb/tb_alsu_seg_display.sv
// tb_alsu_seg_display: randomized and directed check of alsu_seg_display against a decimal display model
module tb_alsu_seg_display;
  localparam int DIV = 4;
  logic clk = 0;
  logic rst = 1;
  logic [5:0] out_in = 0;
  logic [15:0] leds_in = 0;
  logic [3:0] anode;
  logic [6:0] seg;
  logic dp, conv_busy;
  int checks = 0;
  int errors = 0;
  logic [6:0] segs [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  localparam logic [6:0] S_E = 7'b0000110;
  localparam logic [6:0] S_R = 7'b0101111;
  localparam logic [6:0] S_BL = 7'b1111111;
  int mshadow = 0, mval = 0, mbusy = 0, mscan = 0, midx = 0;
  logic [3:0] e_an = 4'hF;
  logic [6:0] e_seg = 7'h7F;
  bit go = 0;

  alsu_seg_display #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .out_in(out_in), .leds_in(leds_in),
    .anode(anode), .seg(seg), .dp(dp), .conv_busy(conv_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] expect_seg(input int k, input int v, input bit e);
    if (e) return k == 3 ? S_E : k == 0 ? S_BL : S_R;
    if (k == 0) return segs[v % 10];
    if (k == 1) return v / 10 == 0 ? S_BL : segs[v / 10];
    return S_BL;
  endfunction

  // reference: a value change takes 6 cycles to reach the digits, display shows the value in decimal
  always @(posedge clk) begin
    if (rst) begin
      mshadow = 0; mval = 0; mbusy = 0; mscan = 0; midx = 0;
      e_an = 4'hF; e_seg = 7'h7F;
    end else begin
      e_an = ~(4'b0001 << midx);
      e_seg = expect_seg(midx, mval, leds_in != 0);
      if (mscan == DIV - 1) begin mscan = 0; midx = (midx + 1) % 4; end
      else mscan++;
      if (mbusy > 0) begin
        mbusy--;
        if (mbusy == 0) mval = mshadow;
      end else if (int'(out_in) != mshadow) begin
        mshadow = out_in;
        mbusy = 6;
      end
    end
    go = 1;
  end

  always @(negedge clk)
    if (go) begin
      chk("anode", anode, e_an);
      chk("seg", seg, e_seg);
      chk("dp", dp, 1);
      chk("busy", conv_busy, mbusy > 0);
    end

  task automatic see(input string tag, input int k, input logic [6:0] e);
    bit hit = 0;
    logic [3:0] want = ~(4'b0001 << k);
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      if (anode == want) hit = 1;
    end
    chk({tag, "_lit"}, hit, 1);
    if (hit) chk(tag, seg, e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n;
    cyc(3);
    chk("rst_anode", anode, 4'b1111);
    chk("rst_seg", seg, 7'b1111111);
    chk("rst_busy", conv_busy, 0);
    rst = 0;
    see("z_d0", 0, segs[0]); see("z_d1", 1, S_BL); see("z_d2", 2, S_BL); see("z_d3", 3, S_BL);
    out_in = 42;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (conv_busy) n++;
    end
    chk("busy42_len", n, 6);
    see("v42_d0", 0, 7'b0100100); see("v42_d1", 1, 7'b0011001);
    see("v42_d2", 2, S_BL); see("v42_d3", 3, S_BL);
    out_in = 63; cyc(10);
    see("v63_d0", 0, 7'b0110000); see("v63_d1", 1, 7'b0000010);
    out_in = 5; cyc(10);
    see("v5_d0", 0, 7'b0010010); see("v5_d1", 1, S_BL);
    out_in = 42; cyc(10);
    leds_in = 16'h8000;
    see("err_d3", 3, S_E); see("err_d2", 2, S_R); see("err_d1", 1, S_R); see("err_d0", 0, S_BL);
    leds_in = 0;
    see("back_d1", 1, 7'b0011001); see("back_d0", 0, 7'b0100100);
    out_in = 0; cyc(10);
    out_in = 42; cyc(2);
    out_in = 17; cyc(20);
    see("v17_d1", 1, 7'b1111001); see("v17_d0", 0, 7'b1111000);
    out_in = 0; cyc(10);
    out_in = 42; cyc(4);
    rst = 1; cyc(1);
    chk("abort_busy", conv_busy, 0);
    chk("abort_anode", anode, 4'b1111);
    chk("abort_seg", seg, 7'b1111111);
    rst = 0; cyc(10);
    see("re42_d0", 0, 7'b0100100); see("re42_d1", 1, 7'b0011001);
    for (int i = 0; i < 300; i++) begin
      out_in = 6'($urandom_range(0, 63));
      leds_in = $urandom_range(0, 3) == 0 ? 16'($urandom_range(1, 65535)) : 16'd0;
      if ($urandom_range(0, 49) == 0) begin
        rst = 1; cyc($urandom_range(1, 3)); rst = 0;
      end
      cyc($urandom_range(1, 20));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alsu_seg_display.md
# alsu_seg_display

Display-side consumer of the ALSU result interface. It samples the ALSU 6-bit `out` and 16-bit `leds` outputs and converts the result to decimal with a sequential double-dabble engine. It drives a 4-digit, common-anode, time-multiplexed 7-segment display on the board. When the ALSU signals an error, the display shows "Err" instead of the number.

## Interface
- REFRESH_DIV, 50000, clock cycles each digit stays lit before the scan advances (minimum 2)
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- out_in  in  6  ALSU result `out`, unsigned 0..63
- leds_in  in  16  ALSU `leds`; any nonzero value is an error indication
- anode  out  4  digit enables, active-low one-hot; bit 0 is the rightmost digit
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low; held at 1 (off)
- conv_busy  out  1  high while a binary-to-BCD conversion is in progress

## Operation
- Reset values (while rst=1, and at the first edge after release):
  - anode=4'b1111, seg=7'b1111111, dp=1, conv_busy=0.
  - Internal state: shadow=0, ones=0, tens=0, scan counter=0, digit index=0, FSM=IDLE.
- Conversion FSM, states IDLE and CONV:
  - IDLE: when out_in != shadow, latch shadow<=out_in, load the shift register, clear the step count, and go to CONV. conv_busy=1 from the next cycle.
  - CONV: each cycle, add 3 to any BCD nibble that is >=5, then shift left by one. After the 6th step, write tens/ones, return to IDLE and drop conv_busy.
  - Changes on out_in during CONV are ignored. If the final out_in differs from shadow on the return to IDLE, a new conversion starts on the next edge.
  - rst mid-conversion aborts it; ones/tens return to 0.
- Digit content, normal mode (leds_in==0):
  - digit0 = ones.
  - digit1 = tens, blanked when tens==0.
  - digit2 and digit3 blank.
- Digit content, error mode (leds_in!=0, evaluated combinationally each cycle):
  - digit3='E', digit2='r', digit1='r', digit0 blank.
  - Conversion continues in the background. The numeric display resumes on the first cycle leds_in==0.
- Segment codes (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - E=0000110, r=0101111, blank=1111111

## Timing
- Scan counter counts 0..REFRESH_DIV-1. On wrap, the digit index advances 0->1->2->3->0.
- anode and seg are registered from the current digit index and content, so each digit is lit for exactly REFRESH_DIV cycles.
- One-hot anode sequence: 1110, 1101, 1011, 0111.
- Conversion latency: out_in changes before edge N, so shadow latches at edge N and CONV runs edges N+1..N+6. conv_busy=1 for those 6 cycles; tens/ones update at edge N+6, and the new value appears in seg from edge N+7.
- Maximum input 63 converts without overflow (tens<=6). No other width rules apply.
- anode is never all-zero and never has two zeros. Only in reset is anode 1111.

## Test plan
- Reset, REFRESH_DIV=4: hold rst 3 cycles -> anode=1111, seg=1111111, conv_busy=0. Release with out_in=0 -> anode steps 1110/1101/1011/0111 every 4 cycles; digit0 seg=1000000, other digits 1111111.
- out_in=42 -> conv_busy high exactly 6 cycles. Then digit0 seg=0100100 ('2'), digit1 seg=0011001 ('4'), digits 2/3 blank.
- out_in=63 -> digit0 '3' (0110000), digit1 '6' (0000010). out_in=5 -> digit0 0010010, digit1 blank.
- leds_in=16'h8000 with out_in=42 -> digit3=0000110, digit2=0101111, digit1=0101111, digit0 blank. leds_in=0 -> '42' returns on the next cycle.
- out_in=42, then 17 two cycles later -> the first conversion completes (6 busy cycles). A second conversion follows immediately, and the display ends at '17' (digit1 1111001, digit0 1111000).
- rst asserted at CONV step 3 of out_in=42 -> next edge: all outputs at reset values, conv_busy=0. After release with out_in still 42, a fresh conversion runs and '42' is displayed.
